// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - state encodings, halt codes and instruction-class type for the sequencer
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] HALT_NONE      = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL   = 2'd1;
    localparam logic [1:0] HALT_FETCH_TMO = 2'd2;
    localparam logic [1:0] HALT_MEM_TMO   = 2'd3;

    typedef struct packed {
        logic branch;
        logic load;
        logic store;
        logic alur;
        logic aluimm;
    } iclass_t;

    // A decoded instruction is usable only when exactly one class flag is set.
    function automatic logic class_is_legal(input iclass_t c);
        return $countones(c) == 1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts stalled memory-request cycles and flags the timeout limit
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     restart the count (no request pending or request completing)
//   count     one more cycle of request without ready
//   expired   count has reached MEM_TIMEOUT-1
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] wait_cnt;

    // Saturates at LAST so the counter can never wrap back to a "fresh" value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt <= '0;
        end else if (count && (wait_cnt != LAST)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (wait_cnt == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the R/I/J CPU
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   run                      execute when 1, pause at next instruction boundary when 0
//   is_branch..is_aluimm     instruction class flags (sampled in DECODE)
//   br_taken                 branch condition (used in EXEC)
//   mem_rdy / mem_req        memory handshake; mem_we, addr_src qualify the request
//   ir_write..alu_imm        datapath strobes and selects
//   busy, halted, halt_code  status; instr_count counts retired instructions
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             is_branch,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_alur,
    input  logic             is_aluimm,
    input  logic             br_taken,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             wb_mem,
    output logic             dst_rd,
    output logic             alu_imm,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    state_t     state_next;
    state_t     boundary_next;
    iclass_t    cls;
    iclass_t    dec_cls;
    logic [1:0] halt_next;
    logic       retire;
    logic       tmo_expired;
    logic       in_req_state;

    assign dec_cls       = {is_branch, is_load, is_store, is_alur, is_aluimm};
    assign boundary_next = run ? ST_FETCH : ST_IDLE;
    assign in_req_state  = (state == ST_FETCH) || (state == ST_MEM);
    assign busy          = (state != ST_IDLE) && (state != ST_HALT);
    assign halted        = (state == ST_HALT);

    // A completing request also restarts the count, which covers the
    // direct MEM -> FETCH hop after a store.
    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_req_state || mem_rdy),
        .count   (mem_req && !mem_rdy),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cls         <= '0;
            halt_code   <= HALT_NONE;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                cls <= dec_cls;
            end
            if ((state_next == ST_HALT) && (state != ST_HALT)) begin
                halt_code <= halt_next;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        halt_next  = HALT_NONE;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        wb_mem     = 1'b0;
        dst_rd     = 1'b0;
        alu_imm    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                // Completion on the last allowed cycle beats the timeout.
                if (mem_rdy) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (tmo_expired) begin
                    halt_next  = HALT_FETCH_TMO;
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (class_is_legal(dec_cls)) begin
                    state_next = ST_EXEC;
                end else begin
                    halt_next  = HALT_ILLEGAL;
                    state_next = ST_HALT;
                end
            end
            ST_EXEC: begin
                alu_imm = cls.aluimm || cls.load || cls.store;
                if (cls.branch) begin
                    pc_write   = br_taken;
                    pc_src     = 1'b1;
                    retire     = 1'b1;
                    state_next = boundary_next;
                end else if (cls.load || cls.store) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                mem_we   = cls.store;
                if (mem_rdy) begin
                    if (cls.load) begin
                        mdr_write  = 1'b1;
                        state_next = ST_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = boundary_next;
                    end
                end else if (tmo_expired) begin
                    halt_next  = HALT_MEM_TMO;
                    state_next = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                wb_mem     = cls.load;
                dst_rd     = cls.alur;
                retire     = 1'b1;
                state_next = boundary_next;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
